// File: rtl/lighting_scheduler.sv
// -----------------------------------------------------------------------------
// lighting_scheduler
//
// Sequencer for the smart-home lighting datapath control inputs.
//   - Rotates the one-hot time-of-day code through morning, noon, evening and
//     night. The code advances once every PHASE_TICKS time-base ticks.
//   - Applies timed user overrides to the light pattern. An override lasts
//     ovr_ticks ticks, can be reloaded, and ovr_ticks == 0 cancels it.
//   - Holds the software-written configuration word.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   en           in   scheduler enable (level)
//   tick         in   time-base strobe, one clk wide
//   ovr_req      in   override request, one clk wide
//   ovr_light    in   [3:0] requested light pattern, sampled with ovr_req
//   ovr_ticks    in   [3:0] override hold time in ticks, 0 = cancel
//   cfg_we       in   write strobe for lenght
//   cfg_len      in   [3:0] new lenght value
//   tcode        out  [3:0] one-hot day phase, 0000 when off
//   ulight       out  [3:0] light pattern to the datapath
//   lenght       out  [3:0] configuration word to the datapath
//   ovr_active   out  override in force
//   phase_strobe out  one-cycle pulse on each tcode change made while running
// -----------------------------------------------------------------------------
module lighting_scheduler #(
    parameter int         PHASE_TICKS = 8,
    parameter logic [3:0] DEFAULT_LEN = 4'b0101
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic       ovr_req,
    input  logic [3:0] ovr_light,
    input  logic [3:0] ovr_ticks,
    input  logic       cfg_we,
    input  logic [3:0] cfg_len,
    output logic [3:0] tcode,
    output logic [3:0] ulight,
    output logic [3:0] lenght,
    output logic       ovr_active,
    output logic       phase_strobe
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Value of phase_cnt_r on the tick that must advance the phase.
    localparam logic [7:0] LAST_CNT = 8'(PHASE_TICKS - 1);

    state_t     state_r;
    logic [7:0] phase_cnt_r;
    logic [3:0] ovr_cnt_r;

    // Configuration register. It is written in any state and is independent of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lenght <= DEFAULT_LEN;
        end else if (cfg_we) begin
            lenght <= cfg_len;
        end else begin
            lenght <= lenght;
        end
    end

    // Scheduler FSM: phase rotation, override timing and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_OFF;
            tcode        <= 4'b0000;
            ulight       <= 4'b0000;
            ovr_active   <= 1'b0;
            phase_strobe <= 1'b0;
            phase_cnt_r  <= 8'd0;
            ovr_cnt_r    <= 4'd0;
        end else begin
            phase_strobe <= 1'b0;
            case (state_r)
                ST_OFF: begin
                    // The off state ignores tick and ovr_req. The outputs are already clear.
                    ulight     <= 4'b0000;
                    ovr_active <= 1'b0;
                    ovr_cnt_r  <= 4'd0;
                    if (en) begin
                        state_r     <= ST_RUN;
                        tcode       <= 4'b0001;
                        phase_cnt_r <= 8'd0;
                    end else begin
                        tcode       <= 4'b0000;
                        phase_cnt_r <= 8'd0;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        // A disable overrides a tick or a request in the same cycle.
                        state_r     <= ST_OFF;
                        tcode       <= 4'b0000;
                        ulight      <= 4'b0000;
                        ovr_active  <= 1'b0;
                        phase_cnt_r <= 8'd0;
                        ovr_cnt_r   <= 4'd0;
                    end else begin
                        if (tick) begin
                            if (phase_cnt_r == LAST_CNT) begin
                                phase_cnt_r  <= 8'd0;
                                tcode        <= {tcode[2:0], tcode[3]};
                                phase_strobe <= 1'b1;
                            end else begin
                                phase_cnt_r  <= phase_cnt_r + 8'd1;
                            end
                        end else begin
                            phase_cnt_r <= phase_cnt_r;
                        end

                        // A request takes priority over the tick decrement.
                        if (ovr_req) begin
                            if (ovr_ticks != 4'd0) begin
                                ulight     <= ovr_light;
                                ovr_cnt_r  <= ovr_ticks;
                                ovr_active <= 1'b1;
                            end else begin
                                ulight     <= 4'b0000;
                                ovr_cnt_r  <= 4'd0;
                                ovr_active <= 1'b0;
                            end
                        end else if (tick && ovr_active) begin
                            if (ovr_cnt_r == 4'd1) begin
                                ulight     <= 4'b0000;
                                ovr_cnt_r  <= 4'd0;
                                ovr_active <= 1'b0;
                            end else begin
                                ovr_cnt_r  <= ovr_cnt_r - 4'd1;
                            end
                        end else begin
                            ovr_cnt_r <= ovr_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_OFF;
                    tcode       <= 4'b0000;
                    ulight      <= 4'b0000;
                    ovr_active  <= 1'b0;
                    phase_cnt_r <= 8'd0;
                    ovr_cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/lighting_scheduler.md
# lighting_scheduler

Sequencer that drives the smart-home lighting subsystem's control inputs: the time-of-day code `tcode`, the user light pattern `ulight` and the configuration word `lenght`. It rotates `tcode` through the four one-hot day phases on a tick time base and applies timed user overrides to `ulight`. It holds `lenght` as a software-written register. It sits between the home controller's time base and user panel, and the lighting datapath.

## Interface
- PHASE_TICKS, 8, ticks per day phase; legal range 1..255.
- DEFAULT_LEN, 4'b0101, reset value of `lenght`.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scheduler enable; level.
- tick  in  1  time-base strobe, one clk wide.
- ovr_req  in  1  user override request, one clk wide.
- ovr_light  in  4  requested light pattern, sampled with `ovr_req`.
- ovr_ticks  in  4  override hold time in ticks, sampled with `ovr_req`; 0 = cancel.
- cfg_we  in  1  write strobe for `lenght`.
- cfg_len  in  4  new `lenght` value.
- tcode  out  4  one-hot day phase (0001 morning, 0010 noon, 0100 evening, 1000 night); 0000 = off.
- ulight  out  4  light pattern to the lighting datapath.
- lenght  out  4  configuration word to the lighting datapath.
- ovr_active  out  1  override in force.
- phase_strobe  out  1  one-cycle pulse on every `tcode` change made inside RUN.

## Operation
- Reset values: state OFF, `tcode` 0000, `ulight` 0000, `lenght` DEFAULT_LEN, `ovr_active` 0, `phase_strobe` 0, phase_cnt 0, ovr_cnt 0.
- FSM, 2 states:
  - OFF: `tcode`=0000. `tick` and `ovr_req` are ignored. `en`=1 -> RUN, with `tcode`=0001 and phase_cnt=0. `phase_strobe` stays 0 on this entry.
  - RUN: `en`=0 -> OFF. On that edge `tcode`=0000, any override is cleared (`ulight`=0000, `ovr_active`=0) and phase_cnt=0.
- Phase counter (RUN only): phase_cnt is 8 bits and advances only on `tick`.
  - On `tick` with phase_cnt==PHASE_TICKS-1: phase_cnt=0, `tcode` rotates left, and 1000 wraps to 0001. `phase_strobe`=1 for exactly that cycle.
  - Otherwise `tick` increments phase_cnt.
  - With PHASE_TICKS=1, every tick advances the phase.
- Override (RUN only), 4-bit ovr_cnt:
  - `ovr_req` with `ovr_ticks`!=0: `ulight`=`ovr_light`, ovr_cnt=`ovr_ticks`, `ovr_active`=1. This also applies while an override is already active (retrigger or reload).
  - `ovr_req` with `ovr_ticks`==0: immediate cancel, `ulight`=0000, `ovr_active`=0.
  - While active, each `tick` decrements ovr_cnt. A `tick` with ovr_cnt==1 ends the override: `ulight`=0000, `ovr_active`=0.
  - `ovr_req` and `tick` in the same cycle: the request wins. The counter loads and is not decremented.
  - Expiry and phase rotation on the same `tick` both take effect on that edge.
- With no override active, `ulight`=0000.
- `lenght`: `cfg_we`=1 loads `cfg_len` in any state, including OFF. It is unaffected by `en`.
- `en`=0 together with `ovr_req` or `tick` in the same cycle: the disable wins.

## Timing
- All outputs are registered.
- Every effect appears on the clk edge that samples the causing input, so it is visible one cycle after the input is presented.
- `tcode` is always exactly one-hot in RUN and always 0000 in OFF.
- Override duration: the override drops on the Nth `tick` after the loading edge, where N=`ovr_ticks`.
- `rst` asserted mid-operation returns all outputs to their reset values immediately, without waiting for a clk edge.
- After `rst` deasserts, the first edge with `en`=1 enters RUN.

## Test plan
- Reset then idle: `rst` pulse with `en`=0 and ticks running -> `tcode`=0000, `ulight`=0000, `lenght`=0101; no `phase_strobe`.
- Phase rotation, PHASE_TICKS=2, `en`=1, 10 ticks -> `tcode` 0001, 0010, 0100, 1000, 0001, 0010 at every 2nd tick, with a one-cycle `phase_strobe` at each change.
- Override expiry: `ovr_req` with `ovr_light`=1001 and `ovr_ticks`=3 -> `ulight`=1001 and `ovr_active`=1 for exactly 3 ticks, then `ulight`=0000.
- Retrigger, cancel and collision cases:
  - Reload: `ovr_req` with `ovr_ticks`=2 after 2 of 3 ticks -> the override lasts 2 more ticks.
  - Cancel: `ovr_req` with `ovr_ticks`=0 -> `ulight`=0000 on the next cycle.
  - Collision: `ovr_req` in the same cycle as `tick` -> no decrement that cycle.
- Disable mid-override: `en`=0 while `ovr_active`=1 -> `tcode`=0000, `ulight`=0000, `ovr_active`=0 next cycle. Re-enabling restarts at `tcode`=0001.
- Config and async reset:
  - `cfg_we` with `cfg_len`=1010 in OFF -> `lenght`=1010.
  - Async `rst` asserted between clk edges while in RUN -> all outputs return to reset values before the next edge, with `lenght`=0101.
